// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ requesters through a round-robin arbiter.
// A bank clear zeroes one register per cycle while all grants are held off.
module reg_bank_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_req,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_rdata,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {RUN, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   bank_q [DEPTH];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_rdata_q;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic               sel_write;

  // Scan offsets from rr_ptr upward; the first valid requester wins and its
  // operands are muxed out with constant slice indices.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    win_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    if (state_q == RUN && !clear_req && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && req_valid[i] && i == (int'(rr_ptr_q) + k) % NUM_REQ) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            win_idx   = PTR_W'(i);
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            sel_write = req_write[i];
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (found) begin
          rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grants are already suppressed in CLEAR, so rsp_valid follows the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) bank_q[j] <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= grant;
      if (state_q == CLEAR) begin
        bank_q[cnt_q] <= '0;
      end else if (found) begin
        if (sel_write) begin
          bank_q[sel_addr] <= sel_wdata;
          rsp_rdata_q      <= sel_wdata;
        end else begin
          rsp_rdata_q <= bank_q[sel_addr];
        end
      end
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of each bank register.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the bank; legal range 2-8.
REQ-003 Parameter DEPTH, default 8: number of registers in the bank; power of two only.
REQ-004 Parameter ADDR_W, default $clog2(DEPTH): register address width.
REQ-005 clk  input  1  single clock; all state updates on the posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_write  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  per-requester register address; requester i occupies slice i.
REQ-010 req_wdata  input  NUM_REQ*WIDTH  per-requester write data; requester i occupies slice i.
REQ-011 req_ready  output  NUM_REQ  grant, one-hot or zero, combinational.
REQ-012 clear_req  input  1  request to zero the whole bank.
REQ-013 rsp_valid  output  NUM_REQ  one-cycle response pulse to the served requester.
REQ-014 rsp_rdata  output  WIDTH  response data, shared by all requesters.
REQ-015 busy  output  1  high while a bank clear is in progress.

Function
REQ-016 The bank SHALL hold DEPTH registers of WIDTH bits each, with at most one access per cycle.
REQ-017 FSM states SHALL be RUN and CLEAR.
REQ-018 In RUN with clear_req=0, the arbiter SHALL grant the first requester with req_valid=1, searching round-robin from rr_ptr upward and wrapping at NUM_REQ.
REQ-019 req_ready SHALL be high only for the winner, only in RUN, and only when clear_req=0; it SHALL be all-zero when no requester is valid.
REQ-020 A transfer SHALL occur when req_valid[i] & req_ready[i]; rr_ptr SHALL then update to (i+1) mod NUM_REQ at the edge, and SHALL hold when no transfer occurs.
REQ-021 On a write transfer: bank[addr] <= wdata at the edge; rsp_rdata <= wdata.
REQ-022 On a read transfer: rsp_rdata <= bank[addr] at the edge.
REQ-023 Every transfer SHALL produce exactly one response: rsp_valid[i]=1 for one cycle, the cycle after the transfer (latency 1).
REQ-024 rsp_rdata SHALL hold its value until the next transfer.
REQ-025 A requester holding req_valid high SHALL be able to win on back-to-back cycles only if no other requester is valid.
REQ-026 RUN with clear_req=1: no grant that cycle; FSM -> CLEAR; clear counter <= 0.
REQ-027 CLEAR: each cycle bank[cnt] <= 0 and cnt++; after writing index DEPTH-1, FSM -> RUN (exactly DEPTH cycles in CLEAR).
REQ-028 In CLEAR: busy=1, req_ready=0, and no rsp_valid is generated.
REQ-029 clear_req SHALL be ignored while in CLEAR.
REQ-030 rr_ptr SHALL be preserved across a clear.
REQ-031 A response owed for a transfer in the cycle before the CLEAR entry cycle SHALL still be delivered.

Reset
REQ-032 On rst assertion, asynchronously and at any state, including mid-CLEAR:
- all bank registers = 0
- rr_ptr = 0, FSM = RUN, cnt = 0
- rsp_valid = 0, rsp_rdata = 0, busy = 0
REQ-033 While rst=1, req_ready SHALL be 0 and no transfer SHALL occur.
REQ-034 The first grant after reset release SHALL follow the round-robin order from requester 0.

Verification
REQ-035 Write then read back: req0 write addr 3 = 0xDEADBEEF, then req0 read addr 3 -> rsp_valid[0] pulses one cycle after each transfer; read rsp_rdata = 0xDEADBEEF.
REQ-036 Fairness: all 4 req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Fairness with gaps: only req1 and req3 held high -> grants alternate 1,3,1,3.
REQ-038 Clear: fill addr 0-7 with 0xFFFFFFFF, pulse clear_req -> busy=1 for exactly 8 cycles with req_ready=0 throughout; then reads of all addresses return 0x00000000.
REQ-039 Reset mid-clear: assert rst on the 3rd CLEAR cycle -> busy=0 immediately; after release, all registers read 0 and the first grant goes to the lowest valid requester index.
REQ-040 Clear collision: clear_req and req2 write asserted in the same RUN cycle -> req_ready=0 that cycle, clear runs, and req2's write completes after clear (value persists; rsp_valid[2] pulses).
